// File: rtl/move_link_ctrl.sv
// Move exchange link: frames local moves onto a UART byte stream with ACK/NAK, timeout and retry,
// and validates/acknowledges peer moves. Define MOVE_LINK_CHECKSUM_EN for 3-byte frames.
module move_link_ctrl #(
  parameter int unsigned AckTimeout = 1_000_000,
  parameter int unsigned MaxRetry   = 3
) (
  input  logic       pclk_i,
  input  logic       rst_ni,
  input  logic       send_req_i,
  input  logic [3:0] send_square_i,
  input  logic       send_player_i,
  input  logic       send_game_over_i,
  input  logic       recv_en_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_done_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       busy_o,
  output logic       send_ok_o,
  output logic       send_fail_o,
  output logic       move_valid_o,
  output logic [3:0] move_square_o,
  output logic       move_player_o,
  output logic       move_game_over_o
);

  localparam int unsigned RetryW = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;
  localparam logic [7:0] AckByte = 8'h06;
  localparam logic [7:0] NakByte = 8'h15;

  typedef enum logic [3:0] {
    StIdle,
    StTxHdr,
    StTxSq,
`ifdef MOVE_LINK_CHECKSUM_EN
    StTxChk,
`endif
    StWaitAck,
    StRxSq,
`ifdef MOVE_LINK_CHECKSUM_EN
    StRxChk,
`endif
    StTxResp,
    StDone
  } state_e;

  state_e            state_q;
  logic [7:0]        hdr_q;
  logic [7:0]        sq_q;
  logic [19:0]       timer_q;
  logic [RetryW-1:0] retry_q;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;
  logic              send_ok_q;
  logic              send_fail_q;
  logic              move_valid_q;
  logic [3:0]        move_square_q;
  logic              move_player_q;
  logic              move_game_over_q;

  logic [7:0] send_hdr;
  logic       timeout;
  logic       retry_left;
  logic       rx_is_hdr;

  assign send_hdr   = {4'hA, 2'b00, send_game_over_i, send_player_i};
  assign timeout    = (timer_q == 20'(AckTimeout - 1));
  assign retry_left = (retry_q < RetryW'(MaxRetry));
  assign rx_is_hdr  = recv_en_i && rx_valid_i && (rx_data_i[7:4] == 4'hA);

  // hdr_q/sq_q hold the outgoing frame while sending and the incoming frame while receiving.
  always_ff @(posedge pclk_i) begin
    if (!rst_ni) begin
      state_q          <= StIdle;
      hdr_q            <= '0;
      sq_q             <= '0;
      timer_q          <= '0;
      retry_q          <= '0;
      tx_start_q       <= 1'b0;
      tx_data_q        <= '0;
      send_ok_q        <= 1'b0;
      send_fail_q      <= 1'b0;
      move_valid_q     <= 1'b0;
      move_square_q    <= '0;
      move_player_q    <= 1'b0;
      move_game_over_q <= 1'b0;
    end else begin
      tx_start_q   <= 1'b0;
      send_ok_q    <= 1'b0;
      send_fail_q  <= 1'b0;
      move_valid_q <= 1'b0;
      timer_q      <= timer_q + 20'd1;
      unique case (state_q)
        StIdle: begin
          if (send_req_i) begin
            if (send_square_i <= 4'd8) begin
              hdr_q      <= send_hdr;
              sq_q       <= {4'h0, send_square_i};
              retry_q    <= '0;
              tx_data_q  <= send_hdr;
              tx_start_q <= 1'b1;
              state_q    <= StTxHdr;
            end else begin
              send_fail_q <= 1'b1;
            end
          end else if (rx_is_hdr) begin
            hdr_q   <= rx_data_i;
            timer_q <= '0;
            state_q <= StRxSq;
          end
        end
        StTxHdr: begin
          if (tx_done_i) begin
            tx_data_q  <= sq_q;
            tx_start_q <= 1'b1;
            state_q    <= StTxSq;
          end
        end
        StTxSq: begin
          if (tx_done_i) begin
`ifdef MOVE_LINK_CHECKSUM_EN
            tx_data_q  <= hdr_q ^ sq_q;
            tx_start_q <= 1'b1;
            state_q    <= StTxChk;
`else
            timer_q <= '0;
            state_q <= StWaitAck;
`endif
          end
        end
`ifdef MOVE_LINK_CHECKSUM_EN
        StTxChk: begin
          if (tx_done_i) begin
            timer_q <= '0;
            state_q <= StWaitAck;
          end
        end
`endif
        StWaitAck: begin
          if (rx_valid_i && (rx_data_i == AckByte)) begin
            send_ok_q <= 1'b1;
            state_q   <= StIdle;
          end else if ((rx_valid_i && (rx_data_i == NakByte)) || timeout) begin
            if (retry_left) begin
              retry_q    <= retry_q + RetryW'(1);
              tx_data_q  <= hdr_q;
              tx_start_q <= 1'b1;
              state_q    <= StTxHdr;
            end else begin
              send_fail_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end
        StRxSq: begin
          if (rx_valid_i) begin
            sq_q    <= rx_data_i;
            timer_q <= '0;
`ifdef MOVE_LINK_CHECKSUM_EN
            state_q <= StRxChk;
`else
            tx_data_q  <= (rx_data_i <= 8'd8) ? AckByte : NakByte;
            tx_start_q <= 1'b1;
            state_q    <= StTxResp;
`endif
          end else if (timeout) begin
            state_q <= StIdle;
          end
        end
`ifdef MOVE_LINK_CHECKSUM_EN
        StRxChk: begin
          if (rx_valid_i) begin
            tx_data_q  <= ((sq_q <= 8'd8) && (rx_data_i == (hdr_q ^ sq_q))) ? AckByte : NakByte;
            tx_start_q <= 1'b1;
            state_q    <= StTxResp;
          end else if (timeout) begin
            state_q <= StIdle;
          end
        end
`endif
        StTxResp: begin
          // The response byte itself records whether the frame was accepted.
          if (tx_done_i) begin
            if (tx_data_q == AckByte) begin
              move_square_q    <= sq_q[3:0];
              move_player_q    <= hdr_q[0];
              move_game_over_q <= hdr_q[1];
              move_valid_q     <= 1'b1;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o           = (state_q != StIdle);
  assign tx_start_o       = tx_start_q;
  assign tx_data_o        = tx_data_q;
  assign send_ok_o        = send_ok_q;
  assign send_fail_o      = send_fail_q;
  assign move_valid_o     = move_valid_q;
  assign move_square_o    = move_square_q;
  assign move_player_o    = move_player_q;
  assign move_game_over_o = move_game_over_q;

endmodule

// File: tb/tb_move_link_ctrl.sv
// Self-checking bench for move_link_ctrl: directed cases plus randomized send/receive trials
// against a frame-level reference model. Honours MOVE_LINK_CHECKSUM_EN like the design.
module tb_move_link_ctrl;

  localparam int AckTimeout = 1000;
  localparam int MaxRetry   = 3;
`ifdef MOVE_LINK_CHECKSUM_EN
  localparam int FrameLen = 3;
`else
  localparam int FrameLen = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send_req = 1'b0;
  logic [3:0] send_square = '0;
  logic       send_player = 1'b0;
  logic       send_game_over = 1'b0;
  logic       recv_en = 1'b0;
  logic       tx_done = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       tx_start_o, busy_o, send_ok_o, send_fail_o, move_valid_o;
  logic [7:0] tx_data_o;
  logic [3:0] move_square_o;
  logic       move_player_o, move_game_over_o;

  move_link_ctrl #(
    .AckTimeout(AckTimeout),
    .MaxRetry  (MaxRetry)
  ) u_dut (
    .pclk_i          (clk),
    .rst_ni          (rst_n),
    .send_req_i      (send_req),
    .send_square_i   (send_square),
    .send_player_i   (send_player),
    .send_game_over_i(send_game_over),
    .recv_en_i       (recv_en),
    .tx_start_o      (tx_start_o),
    .tx_data_o       (tx_data_o),
    .tx_done_i       (tx_done),
    .rx_valid_i      (rx_valid),
    .rx_data_i       (rx_data),
    .busy_o          (busy_o),
    .send_ok_o       (send_ok_o),
    .send_fail_o     (send_fail_o),
    .move_valid_o    (move_valid_o),
    .move_square_o   (move_square_o),
    .move_player_o   (move_player_o),
    .move_game_over_o(move_game_over_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // UART TX model: logs each started byte and answers tx_done after a random latency.
  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         done_cyc[$];
  int         n_done = 0;
  logic [7:0] uart_b;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_start_o) begin
        uart_b = tx_data_o;
        tx_log.push_back(uart_b);
        tx_cyc.push_back(cyc);
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #2;
        check("tx_data_stable", 32'(tx_data_o), 32'(uart_b));
        tx_done = 1'b1;
        @(posedge clk);
        #2;
        tx_done = 1'b0;
        n_done++;
        done_cyc.push_back(cyc);
      end
    end
  end

  int n_ok = 0;
  int n_fail = 0;
  int n_mv = 0;
  int fail_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (send_ok_o) n_ok <= n_ok + 1;
      if (send_fail_o) begin
        n_fail   <= n_fail + 1;
        fail_cyc <= cyc;
      end
      if (move_valid_o) n_mv <= n_mv + 1;
    end
  end

  // Reference model of the last accepted peer move.
  logic [3:0] exp_sq = '0;
  logic       exp_pl = 1'b0;
  logic       exp_go = 1'b0;

  function automatic logic [7:0] frame_byte(input logic [3:0] sq, input logic pl,
                                            input logic go, input int idx);
    logic [7:0] hdr;
    logic [7:0] sqb;
    hdr = 8'hA0 + {6'd0, go, pl};
    sqb = {4'h0, sq};
    if (idx == 0) return hdr;
    if (idx == 1) return sqb;
    return hdr ^ sqb;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_send(input logic [3:0] sq, input logic pl, input logic go);
    send_req       = 1'b1;
    send_square    = sq;
    send_player    = pl;
    send_game_over = go;
    tick(1);
    send_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(n_done >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy_o && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 32'({busy_o, tx_start_o, tx_data_o, send_ok_o, send_fail_o, move_valid_o,
                    move_square_o, move_player_o, move_game_over_o}), 32'd0);
  endtask

  // codes: 2 bits per attempt, 0 = peer ACKs, 2 = peer silent, otherwise peer NAKs.
  task automatic send_trial(input logic [3:0] sq, input logic pl, input logic go,
                            input logic [7:0] codes);
    int attempts, base, nd0, ok0, fail0;
    bit ok;
    attempts = 0;
    ok = 1'b0;
    if (sq <= 4'd8) begin
      for (int k = 0; k <= MaxRetry; k++) begin
        attempts++;
        if (codes[2*k +: 2] == 2'd0) begin
          ok = 1'b1;
          break;
        end
      end
    end
    base  = tx_log.size();
    nd0   = n_done;
    ok0   = n_ok;
    fail0 = n_fail;
    pulse_send(sq, pl, go);
    for (int k = 0; k < attempts; k++) begin
      wait_done(nd0 + (k + 1) * FrameLen, AckTimeout + 200, "send_frame_done");
      if (codes[2*k +: 2] != 2'd2) begin
        tick($urandom_range(1, 40));
        pulse_rx((codes[2*k +: 2] == 2'd0) ? 8'h06 : 8'h15);
      end
    end
    wait_idle(AckTimeout + 200, "send_idle");
    tick(3);
    check("send_tx_len", 32'(tx_log.size() - base), 32'(attempts * FrameLen));
    for (int i = 0; i < attempts * FrameLen && base + i < tx_log.size(); i++)
      check("send_tx_byte", 32'(tx_log[base+i]), 32'(frame_byte(sq, pl, go, i % FrameLen)));
    check("send_ok_count", 32'(n_ok - ok0), 32'(ok));
    check("send_fail_count", 32'(n_fail - fail0), 32'(!ok));
  endtask

  task automatic recv_trial(input logic [7:0] sqb, input logic pl, input logic go,
                            input logic [7:0] corrupt, input logic [7:0] noise);
    logic [7:0] hdr;
    bit valid;
    int base, nd0, mv0;
    hdr   = 8'hA0 + {6'd0, go, pl};
`ifdef MOVE_LINK_CHECKSUM_EN
    valid = (sqb <= 8'd8) && (corrupt == 8'h00);
`else
    valid = (sqb <= 8'd8);
`endif
    base = tx_log.size();
    nd0  = n_done;
    mv0  = n_mv;
    pulse_rx(noise);
    tick($urandom_range(0, 8));
    pulse_rx(hdr);
    tick($urandom_range(0, 8));
    pulse_rx(sqb);
`ifdef MOVE_LINK_CHECKSUM_EN
    tick($urandom_range(0, 8));
    pulse_rx(hdr ^ sqb ^ corrupt);
`endif
    wait_done(nd0 + 1, 200, "resp_done");
    wait_idle(200, "recv_idle");
    tick(3);
    if (valid) begin
      exp_sq = sqb[3:0];
      exp_pl = pl;
      exp_go = go;
    end
    check("resp_len", 32'(tx_log.size() - base), 32'd1);
    check("resp_byte", (tx_log.size() > base) ? 32'(tx_log[base]) : 32'hFFFF_FFFF,
          valid ? 32'h06 : 32'h15);
    check("move_valid_count", 32'(n_mv - mv0), 32'(valid));
    check("move_fields", 32'({move_square_o, move_player_o, move_game_over_o}),
          32'({exp_sq, exp_pl, exp_go}));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nd0, ok0, fail0, mv0, rc, idx, sp;
    tick(3);
    check_reset_outputs("reset_outputs");
    rst_n = 1'b1;
    tick(2);

    // Local move, peer ACKs after 100 cycles.
    base = tx_log.size();
    nd0  = n_done;
    ok0  = n_ok;
    pulse_send(4'd4, 1'b1, 1'b0);
    wait_done(nd0 + FrameLen, 200, "t1_frame_done");
    tick(100);
    pulse_rx(8'h06);
    wait_idle(50, "t1_idle");
    tick(3);
    check("t1_hdr", 32'(tx_log[base]), 32'hA1);
    check("t1_sq", 32'(tx_log[base+1]), 32'h04);
    check("t1_ok", 32'(n_ok - ok0), 32'd1);

    // Silent peer: every attempt times out; frames spaced exactly AckTimeout cycles.
    base = tx_log.size();
    send_trial(4'd2, 1'b0, 1'b0, 8'hAA);
    for (int k = 0; k < MaxRetry; k++) begin
      idx = base + (k + 1) * FrameLen;
      sp  = (idx < tx_cyc.size()) ? tx_cyc[idx] - done_cyc[idx-1] : -1;
      check("t2_retry_spacing", 32'(sp), 32'(AckTimeout));
    end

    // Out-of-range square: immediate send_fail, no bytes.
    rc = cyc;
    pulse_send(4'd9, 1'b0, 1'b0);
    tick(2);
    check("t3_fail_cycle", 32'(fail_cyc), 32'(rc + 1));
    send_trial(4'd9, 1'b1, 1'b1, 8'h00);

    // Incoming frames.
    recv_en = 1'b1;
    recv_trial(8'h07, 1'b1, 1'b1, 8'h00, 8'h12);
`ifdef MOVE_LINK_CHECKSUM_EN
    recv_trial(8'h05, 1'b0, 1'b0, 8'hA5, 8'h33);
`else
    recv_trial(8'h0B, 1'b0, 1'b0, 8'h00, 8'h33);
`endif

    // send_req wins over a same-cycle rx header; rx during TX is ignored.
    base = tx_log.size();
    nd0  = n_done;
    ok0  = n_ok;
    mv0  = n_mv;
    send_req = 1'b1;
    send_square = 4'd6;
    send_player = 1'b0;
    send_game_over = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA3;
    tick(1);
    send_req = 1'b0;
    rx_valid = 1'b0;
    tick(1);
    pulse_rx(8'h06);
    wait_done(nd0 + FrameLen, 200, "t6_frame_done");
    check("t6_no_early_ok", 32'(n_ok - ok0), 32'd0);
    pulse_rx(8'h06);
    wait_idle(50, "t6_idle");
    tick(3);
    check("t6_tx_len", 32'(tx_log.size() - base), 32'(FrameLen));
    check("t6_hdr", 32'(tx_log[base]), 32'(frame_byte(4'd6, 1'b0, 1'b1, 0)));
    check("t6_ok", 32'(n_ok - ok0), 32'd1);
    check("t6_no_move", 32'(n_mv - mv0), 32'd0);

    // Reset while waiting for ACK.
    base = tx_log.size();
    nd0  = n_done;
    pulse_send(4'd5, 1'b0, 1'b1);
    wait_done(nd0 + FrameLen, 200, "t7_frame_done");
    tick(5);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("t7_reset_outputs");
    exp_sq = '0;
    exp_pl = 1'b0;
    exp_go = 1'b0;
    ok0   = n_ok;
    fail0 = n_fail;
    rst_n = 1'b1;
    tick(AckTimeout + 100);
    check("t7_idle", 32'(busy_o), 32'd0);
    check("t7_no_pulse", 32'(n_ok - ok0 + n_fail - fail0), 32'd0);
    check("t7_no_resend", 32'(tx_log.size() - base), 32'(FrameLen));

    // recv_en low: headers are ignored.
    recv_en = 1'b0;
    pulse_rx(8'hA3);
    tick(2);
    check("t8_recv_disabled", 32'(busy_o), 32'd0);
    recv_en = 1'b1;

    // Randomized traffic in both directions.
    for (int t = 0; t < 10; t++) begin
      logic [7:0] codes;
      for (int k = 0; k < 4; k++) begin
        int r;
        r = $urandom_range(0, 9);
        codes[2*k +: 2] = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : 2'd2;
      end
      send_trial(4'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), codes);
      tick(5);
      recv_trial(8'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 8'($urandom_range(0, 159)));
      tick(5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
